// File: rtl/vga_pkg.sv
// Shared timing constants, widths and types for the 800x600@60 VGA timing generator.
// Latency: n/a (declarations only).
// Backpressure: n/a; the display pipeline is free-running and cannot be stalled.
package vga_pkg;

  // 800x600@60 Hz, 40 MHz pixel clock
  localparam int C_H_ACTIVE  = 800;
  localparam int C_H_FP      = 40;
  localparam int C_H_SYNC    = 128;
  localparam int C_H_BP      = 88;
  localparam int C_H_TOTAL   = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;   // 1056

  localparam int C_V_ACTIVE  = 600;
  localparam int C_V_FP      = 1;
  localparam int C_V_SYNC    = 4;
  localparam int C_V_BP      = 23;
  localparam int C_V_TOTAL   = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;   // 628

  localparam int C_H_POL     = 1;
  localparam int C_V_POL     = 1;
  localparam int C_COLOR_W   = 4;
  localparam int C_LOCK_WAIT = 16;

  // Counter / coordinate widths
  localparam int X_W = 11;
  localparam int Y_W = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_t;

  // Stage 1: request side, registered straight from the counters
  typedef struct packed {
    logic           req;
    logic           fs;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           hs;
    logic           vs;
  } s1_t;

  // Stage 2: delay slot that lines sync/enable up with the returning pixel data
  typedef struct packed {
    logic req;
    logic hs;
    logic vs;
  } s2_t;

  // Inclusive window test used for the sync pulses
  function automatic logic in_window(input logic [15:0] v,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_lock_filter.sv
// Synchronizes the asynchronous PLL lock and qualifies it over LOCK_WAIT stable cycles.
// Latency: lock_s 2 cycles after locked; lock_ok a further LOCK_WAIT-1 cycles.
// Backpressure: none; any low cycle on lock_s restarts qualification.
module vga_timing_gen_lock_filter #(
  parameter int LOCK_WAIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_locked,
  output logic o_lock_s,
  output logic o_lock_ok
);

  localparam int CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CW-1:0] L_CNT_MAX = CW'(LOCK_WAIT - 1);

  logic          r_meta;
  logic          r_sync;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer for the PLL lock flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_locked;
      r_sync <= r_meta;
    end
  end

  // Count consecutive locked cycles, saturating; a single low cycle clears it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!r_sync) begin
      r_cnt <= '0;
    end else if (r_cnt != L_CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_lock_s  = r_sync;
  assign o_lock_ok = r_sync & (r_cnt == L_CNT_MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: hsync/vsync/de, pixel-fetch requests and blanked RGB output.
// Latency: hsync/vsync/de/rgb_out lag pixel_req by 2 cycles; rgb_in sampled 1 cycle after pixel_req.
// Backpressure: none; losing PLL lock flushes the pipeline and restarts at (0,0) after requalification.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = C_H_ACTIVE,
  parameter int H_FP      = C_H_FP,
  parameter int H_SYNC    = C_H_SYNC,
  parameter int H_BP      = C_H_BP,
  parameter int V_ACTIVE  = C_V_ACTIVE,
  parameter int V_FP      = C_V_FP,
  parameter int V_SYNC    = C_V_SYNC,
  parameter int V_BP      = C_V_BP,
  parameter int H_POL     = C_H_POL,
  parameter int V_POL     = C_V_POL,
  parameter int COLOR_W   = C_COLOR_W,
  parameter int LOCK_WAIT = C_LOCK_WAIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked,
  output logic                 pixel_req,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic                 frame_start,
  input  logic [3*COLOR_W-1:0] rgb_in,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [3*COLOR_W-1:0] rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] L_H_ACT  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] L_H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] L_V_ACT  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] L_V_LAST = Y_W'(V_TOTAL - 1);

  localparam logic [15:0] L_HS_FIRST = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] L_HS_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] L_VS_FIRST = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] L_VS_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic L_HS_ON  = (H_POL != 0);
  localparam logic L_HS_OFF = ~L_HS_ON;
  localparam logic L_VS_ON  = (V_POL != 0);
  localparam logic L_VS_OFF = ~L_VS_ON;

  logic                 w_lock_s;
  logic                 w_lock_ok;
  vga_state_t           r_state;
  vga_state_t           w_state_nxt;
  logic                 w_run;
  logic                 w_flush;
  logic                 w_adv;
  logic [X_W-1:0]       r_hcnt;
  logic [Y_W-1:0]       r_vcnt;
  s1_t                  w_s1;
  s1_t                  r_s1;
  s2_t                  r_s2;
  logic                 r_hsync;
  logic                 r_vsync;
  logic                 r_de;
  logic [3*COLOR_W-1:0] r_rgb;

  vga_timing_gen_lock_filter #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_filter (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_locked  (locked),
    .o_lock_s  (w_lock_s),
    .o_lock_ok (w_lock_ok)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: start only on qualified lock, drop out on any unlocked cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_lock_ok) w_state_nxt = ST_RUN;
      ST_RUN:  if (!w_lock_s) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: flush covers both idling and the edge that enters IDLE
  always_comb begin
    w_run   = (r_state == ST_RUN);
    w_flush = (w_state_nxt == ST_IDLE);
    w_adv   = w_run & ~w_flush;
  end

  // Raster counters; held at 0 outside RUN so a restart begins at (0,0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (!w_adv) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == L_H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == L_V_LAST) ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // Stage 1 decode of the current raster position
  always_comb begin
    w_s1     = '0;
    w_s1.req = w_run & (r_hcnt < L_H_ACT) & (r_vcnt < L_V_ACT);
    w_s1.fs  = w_run & (r_hcnt == '0) & (r_vcnt == '0);
    w_s1.x   = w_s1.req ? r_hcnt : '0;
    w_s1.y   = w_s1.req ? r_vcnt : '0;
    w_s1.hs  = in_window(16'(r_hcnt), L_HS_FIRST, L_HS_LAST);
    w_s1.vs  = in_window(16'(r_vcnt), L_VS_FIRST, L_VS_LAST);
  end

  // Stage 1 register: request, coordinates and raw sync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
    end else if (w_flush) begin
      r_s1 <= '0;
    end else begin
      r_s1 <= w_s1;
    end
  end

  // Stage 2 register: delay slot covering the frame source's one-cycle read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2 <= '0;
    end else if (w_flush) begin
      r_s2 <= '0;
    end else begin
      r_s2 <= '{req: r_s1.req, hs: r_s1.hs, vs: r_s1.vs};
    end
  end

  // Stage 3 register: polarity-applied sync, data enable and blanked pixel data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync <= L_HS_OFF;
      r_vsync <= L_VS_OFF;
      r_de    <= 1'b0;
      r_rgb   <= '0;
    end else if (w_flush) begin
      r_hsync <= L_HS_OFF;
      r_vsync <= L_VS_OFF;
      r_de    <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_hsync <= r_s2.hs ? L_HS_ON : L_HS_OFF;
      r_vsync <= r_s2.vs ? L_VS_ON : L_VS_OFF;
      r_de    <= r_s2.req;
      r_rgb   <= r_s2.req ? rgb_in : '0;
    end
  end

  assign pixel_req   = r_s1.req;
  assign x           = r_s1.x;
  assign y           = r_s1.y;
  assign frame_start = r_s1.fs;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign rgb_out     = r_rgb;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumes the 40 MHz pixel clock and the `locked` flag from the PLL wrapper.
- Generates 800x600@60 Hz VGA timing: hsync, vsync and data-enable.
- Issues pixel-fetch requests (x, y) to the frame source and returns blanked, pipeline-aligned RGB to the DAC/pins.
- Holds the display idle until PLL lock is stable, and re-arms whenever lock is lost.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, hsync width (clocks)
- H_BP, 88, horizontal back porch (clocks); H_TOTAL = 1056
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines); V_TOTAL = 628
- H_POL, 1, hsync active level
- V_POL, 1, vsync active level
- COLOR_W, 4, bits per colour channel
- LOCK_WAIT, 16, consecutive synchronized-lock cycles required before starting

Ports:
- clk  in  1  pixel clock (40 MHz from PLL outclk_0)
- rst  in  1  asynchronous, active-high reset
- locked  in  1  PLL lock, asynchronous to clk
- pixel_req  out  1  fetch request for pixel (x,y)
- x  out  11  column of the requested pixel
- y  out  10  row of the requested pixel
- frame_start  out  1  one-cycle pulse coincident with the request for (0,0)
- rgb_in  in  3*COLOR_W  pixel data, valid exactly 1 cycle after pixel_req
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active video
- rgb_out  out  3*COLOR_W  pixel data to the DAC; 0 when de=0

Behaviour:
- Reset values:
  - pixel_req, x, y, frame_start, de, rgb_out = 0.
  - hsync = ~H_POL, vsync = ~V_POL.
  - FSM = IDLE; all counters = 0.
- Lock handling:
  - `locked` passes through a 2-FF synchronizer to produce lock_s.
  - lock_cnt increments while lock_s=1 and saturates at LOCK_WAIT-1.
  - lock_s=0 clears lock_cnt.
- FSM states:
  - IDLE -> RUN when lock_s=1 and lock_cnt=LOCK_WAIT-1.
  - RUN -> IDLE on any cycle with lock_s=0.
  - No other transitions.
- Counters (RUN only):
  - hcnt runs 0..H_TOTAL-1, then wraps to 0.
  - vcnt increments when hcnt wraps; vcnt runs 0..V_TOTAL-1, then wraps to 0.
  - In IDLE, both counters are held at 0.
- Stage 1 (registered from the counters):
  - pixel_req = RUN & hcnt<H_ACTIVE & vcnt<V_ACTIVE.
  - x = hcnt and y = vcnt when pixel_req=1; otherwise x and y are 0.
  - frame_start = RUN & hcnt=0 & vcnt=0.
  - hs_raw = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 840..967.
  - vs_raw = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 601..604.
- Stage 2: delay register for hs_raw, vs_raw and pixel_req.
- Stage 3 (registered outputs):
  - hsync = hs_raw ? H_POL : ~H_POL; vsync likewise with V_POL.
  - de = delayed pixel_req.
  - rgb_out = de ? rgb_in (sampled in stage 2) : 0.
- Latency:
  - hsync, vsync and de lag pixel_req by exactly 2 cycles.
  - rgb_in is sampled exactly 1 cycle after its pixel_req.
- Lock loss:
  - Entering IDLE forces all stage registers to their reset values on the same edge; no partial pixels are emitted.
  - The restart begins a fresh frame at (0,0).
- Lock glitch: a lock_s low pulse of 1 cycle still restarts the LOCK_WAIT count.
- Async rst: mid-frame assertion immediately returns every output to its reset value.
- rgb_in is ignored outside the sampled cycle.

Decomposition:
- vga_pkg:
  - 800x600@60 timing constants and derived H_TOTAL/V_TOTAL.
  - Counter widths (11/10).
  - FSM state enum {IDLE, RUN}.
- Sub-module lock_filter: 2-FF synchronizer plus LOCK_WAIT qualification counter; output lock_ok.
- Counters, FSM and output pipeline stay in the top module.

Test Plan:
1. Startup: rst=1 then 0 with locked=0 -> outputs stay at reset values. Raise locked -> first frame_start exactly LOCK_WAIT+3 cycles later (19), with x=0, y=0, pixel_req=1.
2. Line timing over one line:
   - de high for 800 cycles.
   - hsync rises 40 cycles after de falls and stays high 128 cycles.
   - hsync period 1056 cycles.
3. Frame timing:
   - vsync period 663168 cycles, high 4224 cycles.
   - 480000 de-cycles per frame.
   - First vsync edge 601*1056 cycles after frame_start, plus 2 cycles of pipeline latency.
4. Data alignment:
   - Model returns rgb_in = {x[3:0], y[3:0], 4'hA} one cycle after pixel_req.
   - rgb_out matches the model for every pixel with de=1, and is 0 during blanking.
5. Lock loss at (x=400, y=300):
   - Drop locked -> within 3 cycles all outputs are inactive and pixel_req=0.
   - Restore locked -> frame_start LOCK_WAIT+3 cycles later at (0,0).
6. Async reset mid-frame with vsync active:
   - Assert rst between clock edges -> outputs reset immediately.
   - On release with locked=1, behaviour matches scenario 1.
